sdes_ctr_keystream: RTL and testbench

Counter-mode keystream generator for the StreamEsdes cipher path: encrypts (nonce XOR counter) with simplified DES (10-bit key, 8-bit block, two Feistel rounds) and hands each 8-bit keystream byte to the downstream XOR stage over a valid/ready handshake. It sits directly upstream of the plaintext/ciphertext combiner. The combiner XORs `ks_byte` with the data byte on each accepted transfer. One round is computed per clock.

---
 rtl/sdes_ctr_keystream.sv | 171 +++++++++++++++++
 tb/tb_sdes_ctr_keystream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sdes_ctr_keystream.sv
// Purpose  : counter-mode keystream source; each byte = S-DES_K(nonce ^ ctr), one Feistel round per clock.
// Latency  : start sampled at edge N -> ks_valid_o high after edge N+2; one byte per 3 cycles with ks_ready_i high.
// Backpres.: ks_byte_o/ks_valid_o/ctr_o held stable in OUT until ks_ready_i; start_i aborts and restarts at any time.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle pulse: latch key_i/nonce_i, reload counter, begin generation
//   key_i        10-bit S-DES key (sampled on start_i only)
//   nonce_i      8-bit nonce (sampled on start_i only)
//   ks_ready_i   downstream combiner accepts ks_byte_o this cycle
//   ks_valid_o   ks_byte_o holds a valid keystream byte
//   ks_byte_o    keystream byte
//   ctr_o        counter value of the block being computed or held
//   busy_o       generator is not idle
//   ctr_wrap_o   sticky flag: counter wrapped FF->00 (keystream reuse), cleared by start_i
module sdes_ctr_keystream #(
    parameter logic [7:0] CTR_INIT = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [9:0] key_i,
    input  logic [7:0] nonce_i,
    input  logic       ks_ready_i,
    output logic       ks_valid_o,
    output logic [7:0] ks_byte_o,
    output logic [7:0] ctr_o,
    output logic       busy_o,
    output logic       ctr_wrap_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, R1 = 2'd1, R2 = 2'd2, OUT = 2'd3} state_t;

    // S-box tables, entry {row,col}=0 in the top two bits.
    localparam logic [31:0] S0_TBL = {2'd1, 2'd0, 2'd3, 2'd2,  2'd3, 2'd2, 2'd1, 2'd0,
                                      2'd0, 2'd2, 2'd1, 2'd3,  2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [31:0] S1_TBL = {2'd0, 2'd1, 2'd2, 2'd3,  2'd2, 2'd0, 2'd1, 2'd3,
                                      2'd3, 2'd0, 2'd1, 2'd0,  2'd2, 2'd1, 2'd0, 2'd3};

    state_t      state_q, state_d;
    logic [9:0]  key_q;
    logic [7:0]  nonce_q;
    logic [7:0]  ctr_q;
    logic [7:0]  mid_q;
    logic [7:0]  ks_byte_q;
    logic        ks_valid_q;
    logic        ctr_wrap_q;

    // Cipher bit 1 is the MSB, so cipher position p of an N-bit word is index N-p.
    function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [1:0] row,
                                        input logic [1:0] col);
        logic [31:0] sh;
        sh = tbl << {row, col, 1'b0};
        return sh[31:30];
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] v);
        return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] b);
        return {b[6], b[2], b[5], b[7], b[4], b[0], b[3], b[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] b);
        return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
    endfunction

    // One Feistel round: left nibble ^= P4(S(E/P(right) ^ sk)), right nibble passes through.
    function automatic logic [7:0] fk(input logic [7:0] b, input logic [7:0] sk);
        logic [7:0] x;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [3:0] p4;
        x  = {b[0], b[3], b[2], b[1], b[2], b[1], b[0], b[3]} ^ sk;
        s0 = sbox(S0_TBL, {x[7], x[4]}, {x[6], x[5]});
        s1 = sbox(S1_TBL, {x[3], x[0]}, {x[2], x[1]});
        p4 = {s0[0], s1[0], s1[1], s0[1]};
        return {b[7:4] ^ p4, b[3:0]};
    endfunction

    // Key schedule from the latched key: P10, then rotate each 5-bit half by 1 (K1) or 3 (K2).
    logic [9:0] p10;
    logic [9:0] ls1;
    logic [9:0] ls3;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] r1_f;
    logic [7:0] mid_d;
    logic [7:0] ks_byte_d;

    assign p10 = {key_q[7], key_q[5], key_q[8], key_q[3], key_q[6],
                  key_q[0], key_q[9], key_q[1], key_q[2], key_q[4]};
    assign ls1 = {p10[8:5], p10[9], p10[3:0], p10[4]};
    assign ls3 = {p10[6:5], p10[9:7], p10[1:0], p10[4:2]};
    assign k1  = p8(ls1);
    assign k2  = p8(ls3);

    assign r1_f      = fk(ip(nonce_q ^ ctr_q), k1);
    assign mid_d     = {r1_f[3:0], r1_f[7:4]};
    assign ks_byte_d = ip_inv(fk(mid_q, k2));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start_i overrides everything, including a same-cycle accept.
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = R1;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                R1:      state_d = R2;
                R2:      state_d = OUT;
                OUT:     if (ks_ready_i) state_d = R1;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q      <= '0;
            nonce_q    <= '0;
            ctr_q      <= CTR_INIT;
            mid_q      <= '0;
            ks_byte_q  <= '0;
            ks_valid_q <= 1'b0;
            ctr_wrap_q <= 1'b0;
        end else if (start_i) begin
            key_q      <= key_i;
            nonce_q    <= nonce_i;
            ctr_q      <= CTR_INIT;
            ctr_wrap_q <= 1'b0;
            ks_valid_q <= 1'b0;
        end else begin
            case (state_q)
                R1: mid_q <= mid_d;
                R2: begin
                    ks_byte_q  <= ks_byte_d;
                    ks_valid_q <= 1'b1;
                end
                OUT: if (ks_ready_i) begin
                    ks_valid_q <= 1'b0;
                    ctr_q      <= ctr_q + 8'd1;
                    if (ctr_q == 8'hFF) ctr_wrap_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy_o     = (state_q != IDLE);
        ks_valid_o = ks_valid_q;
        ks_byte_o  = ks_byte_q;
        ctr_o      = ctr_q;
        ctr_wrap_o = ctr_wrap_q;
    end

endmodule

// File: tb/tb_sdes_ctr_keystream.sv
module tb_sdes_ctr_keystream;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic [9:0] key_i;
    logic [7:0] nonce_i;
    logic       ks_ready_i;
    logic       ks_valid_o;
    logic [7:0] ks_byte_o;
    logic [7:0] ctr_o;
    logic       busy_o;
    logic       ctr_wrap_o;

    int errors = 0;
    int checks = 0;

    localparam logic [9:0] KEY_A = 10'b1010000010;
    localparam logic [9:0] KEY_0 = 10'b0000000000;
    localparam logic [9:0] KEY_B = 10'b1110001110;
    localparam logic [9:0] KEY_1 = 10'b1111111111;

    sdes_ctr_keystream #(.CTR_INIT(8'h00)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .key_i      (key_i),
        .nonce_i    (nonce_i),
        .ks_ready_i (ks_ready_i),
        .ks_valid_o (ks_valid_o),
        .ks_byte_o  (ks_byte_o),
        .ctr_o      (ctr_o),
        .busy_o     (busy_o),
        .ctr_wrap_o (ctr_wrap_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start(input logic [9:0] k, input logic [7:0] n);
        key_i   = k;
        nonce_i = n;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Start with ks_ready low, check the 3-cycle latency and the first byte.
    task automatic kat(input string tag, input logic [9:0] k, input logic [7:0] n,
                       input logic [7:0] exp);
        ks_ready_i = 1'b0;
        pulse_start(k, n);
        check({tag, "_r1_valid"}, ks_valid_o, 0);
        tick();
        check({tag, "_r2_valid"}, ks_valid_o, 0);
        tick();
        check({tag, "_valid"}, ks_valid_o, 1);
        check({tag, "_byte"}, ks_byte_o, exp);
        check({tag, "_ctr"}, ctr_o, 8'h00);
    endtask

    // Single-cycle accept from OUT, then wait for the next byte.
    task automatic accept_and_wait();
        ks_ready_i = 1'b1;
        tick();
        ks_ready_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        key_i      = '0;
        nonce_i    = '0;
        ks_ready_i = 1'b0;
        #12;
        check("rst_valid", ks_valid_o, 0);
        check("rst_byte", ks_byte_o, 8'h00);
        check("rst_ctr", ctr_o, 8'h00);
        check("rst_busy", busy_o, 0);
        check("rst_wrap", ctr_wrap_o, 0);
        rst_ni = 1'b1;
        #3;
        tick();
        check("idle_busy", busy_o, 0);

        // Known answer, first transaction latency
        pulse_start(KEY_A, 8'h97);
        check("kat_busy", busy_o, 1);
        check("kat_r1_valid", ks_valid_o, 0);
        tick();
        check("kat_r2_valid", ks_valid_o, 0);
        tick();
        check("kat_valid", ks_valid_o, 1);
        check("kat_byte", ks_byte_o, 8'h38);

        // Backpressure: 10 cycles held
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", ks_valid_o, 1);
            check("bp_byte", ks_byte_o, 8'h38);
            check("bp_ctr", ctr_o, 8'h00);
        end
        accept_and_wait();
        check("bp_next_valid", ks_valid_o, 1);
        check("bp_next_ctr", ctr_o, 8'h01);

        // Vector sweep
        kat("vec_k0", KEY_0, 8'hAA, 8'h11);
        kat("vec_kb", KEY_B, 8'hAA, 8'hCA);
        kat("vec_k1", KEY_1, 8'hFF & 8'hAA, 8'h04);
        kat("vec_kb55", KEY_B, 8'h55, 8'h70);

        // start and ks_ready in the same OUT cycle: start wins, no increment
        ks_ready_i = 1'b1;
        pulse_start(KEY_A, 8'h96);
        ks_ready_i = 1'b0;
        check("sr_valid", ks_valid_o, 0);
        check("sr_ctr", ctr_o, 8'h00);
        tick();
        tick();
        check("ctr0_valid", ks_valid_o, 1);
        // ctr=1 -> block 0x96^0x01 = 0x97 -> known answer again
        accept_and_wait();
        check("ctr1_valid", ks_valid_o, 1);
        check("ctr1_ctr", ctr_o, 8'h01);
        check("ctr1_byte", ks_byte_o, 8'h38);

        // Wrap: nonce AA key B; ctr FF -> block 55 -> 70, ctr 00 -> CA
        kat("wrap_first", KEY_B, 8'hAA, 8'hCA);
        for (int i = 1; i <= 256; i++) begin
            accept_and_wait();
            check("wrap_valid", ks_valid_o, 1);
            check("wrap_ctr", ctr_o, i & 8'hFF);
            check("wrap_flag", ctr_wrap_o, (i == 256) ? 1 : 0);
            if (i == 255) check("wrap_ff_byte", ks_byte_o, 8'h70);
        end
        check("wrap_00_byte", ks_byte_o, 8'hCA);
        accept_and_wait();
        check("wrap_sticky", ctr_wrap_o, 1);
        check("wrap_ctr1", ctr_o, 8'h01);

        // Restart during R2 with ctr nonzero
        ks_ready_i = 1'b1;
        tick();
        ks_ready_i = 1'b0;
        check("pre_r2_ctr", ctr_o, 8'h02);
        tick();
        pulse_start(KEY_B, 8'h55);
        check("rs_valid", ks_valid_o, 0);
        check("rs_ctr", ctr_o, 8'h00);
        check("rs_wrap", ctr_wrap_o, 0);
        tick();
        check("rs_r2_valid", ks_valid_o, 0);
        tick();
        check("rs_valid3", ks_valid_o, 1);
        check("rs_byte", ks_byte_o, 8'h70);

        // Asynchronous reset mid-R1
        accept_and_wait();
        ks_ready_i = 1'b1;
        tick();
        ks_ready_i = 1'b0;
        check("r1_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", ks_valid_o, 0);
        check("arst_byte", ks_byte_o, 8'h00);
        check("arst_ctr", ctr_o, 8'h00);
        check("arst_busy", busy_o, 0);
        check("arst_wrap", ctr_wrap_o, 0);
        #10;
        rst_ni = 1'b1;
        tick();
        check("post_rst_busy", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
